// File: rtl/systolic_sequencer.sv
// Job controller for an NxN output-stationary MAC array: clear, skewed operand streaming, drain.
// Latency: start accepted at T0 -> done at T0+K+2N+3 (k_len==0 -> done at T0+1).
// Backpressure: none; operand buffer answers rd_en a fixed cycle later, start ignored while busy.
//
// Ports:
//   clk, rst                   clock and asynchronous active-high reset
//   start, k_len               job request (sampled in IDLE only) and inner dimension K
//   busy, done                 job in progress / one-cycle completion pulse
//   rd_en, rd_addr             operand buffer read strobe and index k (0 when not reading)
//   rd_a, rd_b                 buffer data, valid the cycle after rd_en
//   a_edge, b_edge             skewed operands into the array west / north edges
//   array_load, array_clr      array accumulate enable / accumulator clear
//   c_capture                  array C outputs valid for collection

module systolic_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 4,
    parameter int KW         = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [KW-1:0]           k_len,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [KW-1:0]           rd_addr,
    input  logic [N*DATA_WIDTH-1:0] rd_a,
    input  logic [N*DATA_WIDTH-1:0] rd_b,
    output logic [N*DATA_WIDTH-1:0] a_edge,
    output logic [N*DATA_WIDTH-1:0] b_edge,
    output logic                    array_load,
    output logic                    array_clr,
    output logic                    c_capture
);

    localparam int CW = KW + 5;
    // Extra run cycles beyond K: N-1 lanes of skew plus N-1 hops to the far corner.
    localparam logic [CW-1:0] SKEW_SPAN = CW'(2 * N - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [KW-1:0]   k_q, k_d;
    logic [CW-1:0]   target_q, target_d;
    logic            drain_q, drain_d;
    logic            rd_vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            k_q      <= '0;
            target_q <= '0;
            drain_q  <= 1'b0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            target_q <= target_d;
            drain_q  <= drain_d;
            rd_vld_q <= rd_en;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        target_d = target_q;
        drain_d  = drain_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (k_len != '0) begin
                        k_d      = k_len;
                        // Full-width sum, so a large K cannot wrap the end-of-run compare.
                        target_d = CW'(k_len) + SKEW_SPAN;
                        state_d  = S_CLEAR;
                    end else begin
                        state_d  = S_DONE;
                    end
                end
            end
            S_CLEAR: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (cnt_q == target_q) begin
                    drain_d = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q) begin
                    drain_d = 1'b0;
                    state_d = S_DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All controls decode from registered state, so reset forces them low immediately.
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign array_clr  = (state_q == S_CLEAR);
    assign rd_en      = (state_q == S_RUN) && (cnt_q < CW'(k_q));
    assign rd_addr    = rd_en ? cnt_q[KW-1:0] : '0;
    // Load starts one cycle into RUN, when the first element reaches lane 0.
    assign array_load = (state_q == S_RUN) && (cnt_q != '0);
    assign c_capture  = (state_q == S_DRAIN) && drain_q;

    // Lane 0 forwards the buffer's registered output directly; lane i adds i stages.
    // Each stage carries a valid bit and invalid lanes drive zero (inert padding).
    for (genvar i = 0; i < N; i++) begin : g_lane
        if (i == 0) begin : g_direct
            assign a_edge[0 +: DATA_WIDTH] = rd_vld_q ? rd_a[0 +: DATA_WIDTH] : '0;
            assign b_edge[0 +: DATA_WIDTH] = rd_vld_q ? rd_b[0 +: DATA_WIDTH] : '0;
        end else begin : g_skew
            logic [DATA_WIDTH-1:0] a_sr_q [i];
            logic [DATA_WIDTH-1:0] b_sr_q [i];
            logic [i-1:0]          v_sr_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < i; s++) begin
                        a_sr_q[s] <= '0;
                        b_sr_q[s] <= '0;
                    end
                    v_sr_q <= '0;
                end else begin
                    a_sr_q[0] <= rd_a[i*DATA_WIDTH +: DATA_WIDTH];
                    b_sr_q[0] <= rd_b[i*DATA_WIDTH +: DATA_WIDTH];
                    v_sr_q[0] <= rd_vld_q;
                    for (int s = 1; s < i; s++) begin
                        a_sr_q[s] <= a_sr_q[s-1];
                        b_sr_q[s] <= b_sr_q[s-1];
                        v_sr_q[s] <= v_sr_q[s-1];
                    end
                end
            end

            assign a_edge[i*DATA_WIDTH +: DATA_WIDTH] = v_sr_q[i-1] ? a_sr_q[i-1] : '0;
            assign b_edge[i*DATA_WIDTH +: DATA_WIDTH] = v_sr_q[i-1] ? b_sr_q[i-1] : '0;
        end
    end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer: one N=2 and one N=4 instance, 8-bit lanes.
// Expected cycle-by-cycle outputs come from the job timeline (T0 = start edge).
// Buffer model returns all-ones when not read, so unmasked padding shows up on the edges.

module tb_systolic_sequencer;

    localparam int DW = 8;
    localparam int KW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- N=4 instance ----------------
    logic            start4;
    logic [KW-1:0]   klen4;
    logic            busy4, done4, rden4, load4, clr4, cap4;
    logic [KW-1:0]   addr4;
    logic [4*DW-1:0] rda4, rdb4, aedge4, bedge4;

    systolic_sequencer #(.DATA_WIDTH(DW), .N(4), .KW(KW)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .k_len(klen4),
        .busy(busy4), .done(done4), .rd_en(rden4), .rd_addr(addr4),
        .rd_a(rda4), .rd_b(rdb4), .a_edge(aedge4), .b_edge(bedge4),
        .array_load(load4), .array_clr(clr4), .c_capture(cap4)
    );

    // ---------------- N=2 instance ----------------
    logic            start2;
    logic [KW-1:0]   klen2;
    logic            busy2, done2, rden2, load2, clr2, cap2;
    logic [KW-1:0]   addr2;
    logic [2*DW-1:0] rda2, rdb2, aedge2, bedge2;

    systolic_sequencer #(.DATA_WIDTH(DW), .N(2), .KW(KW)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .k_len(klen2),
        .busy(busy2), .done(done2), .rd_en(rden2), .rd_addr(addr2),
        .rd_a(rda2), .rd_b(rdb2), .a_edge(aedge2), .b_edge(bedge2),
        .array_load(load2), .array_clr(clr2), .c_capture(cap2)
    );

    function automatic logic [DW-1:0] mem_a(input int k, input int i);
        return DW'(16 * k + i + 1);
    endfunction

    function automatic logic [DW-1:0] mem_b(input int k, input int i);
        return DW'(128 + 16 * k + i);
    endfunction

    // Synchronous operand buffers: data the cycle after rd_en, all-ones otherwise.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            rda4[i*DW +: DW] <= rden4 ? mem_a(int'(addr4), i) : '1;
            rdb4[i*DW +: DW] <= rden4 ? mem_b(int'(addr4), i) : '1;
        end
        rda2 <= rden2 ? 16'h0302 : 16'hFFFF;
        rdb2 <= rden2 ? 16'h0504 : 16'hFFFF;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected N=4 edge word at cycle c: lane i carries element c-3-i.
    function automatic logic [4*DW-1:0] exp_edge4(input int c, input int k_job, input bit is_b);
        logic [4*DW-1:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            int kk;
            kk = c - 3 - i;
            if (k_job != 0 && kk >= 0 && kk < k_job)
                w[i*DW +: DW] = is_b ? mem_b(kk, i) : mem_a(kk, i);
        end
        return w;
    endfunction

    // Run one N=4 job from IDLE, checking every output in every cycle up to the idle cycle after done.
    task automatic run_job4(input int k_job, input bit kchg, input bit hold);
        int  len;
        bit  kz;
        klen4  = KW'(k_job);
        start4 = 1'b1;
        @(posedge clk);   // edge T0
        #1;
        if (!hold) start4 = 1'b0;
        kz  = (k_job == 0);
        len = kz ? 2 : k_job + 12;
        for (int c = 1; c <= len; c++) begin
            logic be, de, ce, re, le, pe;
            logic [KW-1:0] ae;
            @(negedge clk);
            if (kchg && c == 3) klen4 = 8'd200;
            be = kz ? (c == 1) : (c <= k_job + 11);
            de = kz ? (c == 1) : (c == k_job + 11);
            ce = !kz && (c == 1);
            re = !kz && (c >= 2) && (c <= k_job + 1);
            ae = re ? KW'(c - 2) : '0;
            le = !kz && (c >= 3) && (c <= k_job + 8);
            pe = !kz && (c == k_job + 10);
            check_eq($sformatf("k%0d_c%0d_busy", k_job, c), 64'(busy4), 64'(be));
            check_eq($sformatf("k%0d_c%0d_done", k_job, c), 64'(done4), 64'(de));
            check_eq($sformatf("k%0d_c%0d_clr", k_job, c), 64'(clr4), 64'(ce));
            check_eq($sformatf("k%0d_c%0d_rd_en", k_job, c), 64'(rden4), 64'(re));
            check_eq($sformatf("k%0d_c%0d_rd_addr", k_job, c), 64'(addr4), 64'(ae));
            check_eq($sformatf("k%0d_c%0d_load", k_job, c), 64'(load4), 64'(le));
            check_eq($sformatf("k%0d_c%0d_capture", k_job, c), 64'(cap4), 64'(pe));
            check_eq($sformatf("k%0d_c%0d_a_edge", k_job, c), 64'(aedge4), 64'(exp_edge4(c, k_job, 1'b0)));
            check_eq($sformatf("k%0d_c%0d_b_edge", k_job, c), 64'(bedge4), 64'(exp_edge4(c, k_job, 1'b1)));
        end
        if (hold) begin
            // Start still high: re-sampled in the IDLE cycle, so the next clear lands one later.
            @(negedge clk);
            check_eq("hold_reclear", 64'(clr4), 64'd1);
            start4 = 1'b0;
            for (int j = 2; j <= k_job + 12; j++) begin
                @(negedge clk);
                check_eq($sformatf("hold_job2_j%0d_done", j), 64'(done4), 64'(j == k_job + 11));
            end
        end
    endtask

    logic [8:0] t_clr, t_rden, t_load, t_cap, t_done, t_busy;

    initial begin
        bit seen_done;
        rst    = 1'b1;
        start4 = 1'b0;
        klen4  = '0;
        start2 = 1'b0;
        klen2  = '0;
        #1;
        check_eq("rst_busy4", 64'(busy4), 64'd0);
        check_eq("rst_done4", 64'(done4), 64'd0);
        check_eq("rst_rd_en4", 64'(rden4), 64'd0);
        check_eq("rst_a_edge4", 64'(aedge4), 64'd0);
        check_eq("rst_busy2", 64'(busy2), 64'd0);
        check_eq("rst_b_edge2", 64'(bedge2), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // ---- N=2, K=1 directed timeline ----
        t_clr  = 9'b000000001;
        t_rden = 9'b000000010;
        t_load = 9'b000011100;
        t_cap  = 9'b001000000;
        t_done = 9'b010000000;
        t_busy = 9'b011111111;
        klen2  = 8'd1;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            logic [15:0] ae, be;
            @(negedge clk);
            ae = (c == 3) ? 16'h0002 : (c == 4) ? 16'h0300 : 16'h0000;
            be = (c == 3) ? 16'h0004 : (c == 4) ? 16'h0500 : 16'h0000;
            check_eq($sformatf("n2_c%0d_clr", c), 64'(clr2), 64'(t_clr[c-1]));
            check_eq($sformatf("n2_c%0d_rd_en", c), 64'(rden2), 64'(t_rden[c-1]));
            check_eq($sformatf("n2_c%0d_rd_addr", c), 64'(addr2), 64'd0);
            check_eq($sformatf("n2_c%0d_load", c), 64'(load2), 64'(t_load[c-1]));
            check_eq($sformatf("n2_c%0d_capture", c), 64'(cap2), 64'(t_cap[c-1]));
            check_eq($sformatf("n2_c%0d_done", c), 64'(done2), 64'(t_done[c-1]));
            check_eq($sformatf("n2_c%0d_busy", c), 64'(busy2), 64'(t_busy[c-1]));
            check_eq($sformatf("n2_c%0d_a_edge", c), 64'(aedge2), 64'(ae));
            check_eq($sformatf("n2_c%0d_b_edge", c), 64'(bedge2), 64'(be));
        end

        // ---- N=4 jobs ----
        run_job4(3, 1'b0, 1'b0);
        run_job4(0, 1'b0, 1'b0);
        run_job4(2, 1'b0, 1'b1);
        run_job4(4, 1'b1, 1'b0);

        // ---- async reset mid-RUN at cnt=5 (cycle T7) ----
        klen4  = 8'd8;
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        check_eq("pre_rst_a_edge", 64'(aedge4), 64'(exp_edge4(7, 8, 1'b0)));
        check_eq("pre_rst_load", 64'(load4), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", 64'(busy4), 64'd0);
        check_eq("mid_rst_done", 64'(done4), 64'd0);
        check_eq("mid_rst_rd_en", 64'(rden4), 64'd0);
        check_eq("mid_rst_rd_addr", 64'(addr4), 64'd0);
        check_eq("mid_rst_load", 64'(load4), 64'd0);
        check_eq("mid_rst_clr", 64'(clr4), 64'd0);
        check_eq("mid_rst_capture", 64'(cap4), 64'd0);
        check_eq("mid_rst_a_edge", 64'(aedge4), 64'd0);
        check_eq("mid_rst_b_edge", 64'(bedge4), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done4) seen_done = 1'b1;
        end
        check_eq("aborted_job_no_done", 64'(seen_done), 64'd0);
        run_job4(1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
